// File: rtl/wb_load_store_master_if.sv
// Bundle of the CPU-side load/store handshake and the Wishbone B4 classic
// bus. The master modport is the view used by wb_load_store_master. The slave
// modport is the view used by whatever sits around it: the CPU side and the
// memory/peripheral slave.
interface wb_load_store_master_if;
    // Request side: a request is taken on any rising edge where req_valid_i and
    // req_ready_o are both high. The request fields only need to be stable at
    // that edge. Response side: rsp_valid_o is a one-cycle pulse and cannot be
    // stalled. rsp_err_o and rsp_rdata_o are meaningful only while it is high.
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    // Wishbone classic
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_signed_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        input  dat_i, ack_i, err_i, rty_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_signed_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        output dat_i, ack_i, err_i, rty_i
    );
endinterface

// File: rtl/wb_load_store_master.sv
// Wishbone B4 classic master for single CPU loads and stores (byte, half or
// word). Each request becomes one bus cycle. The block builds the byte selects
// and replicates store data across the lanes. It extracts and extends load
// data. It reports misalignment, slave error, retry exhaustion and timeout as
// an error response. dbg_state_o mirrors the FSM state
// (0 IDLE, 1 BUS, 2 GAP, 3 RESP).
module wb_load_store_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    wb_load_store_master_if.master bus,
    output logic [1:0]             dbg_state_o
);

    localparam int              RW       = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [RW-1:0]   RTY_MAX  = RW'(MAX_RETRIES);
    localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_GAP  = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic            signed_q, signed_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [15:0]     tmo_cnt_q, tmo_cnt_d;
    logic [RW-1:0]   rty_cnt_q, rty_cnt_d;

    // Byte lanes touched by an access. An illegal size selects no lane.
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] s;
        s = 4'b0000;
        case (size)
            2'b00:   s = 4'b0001 << a;
            2'b01:   s = a[1] ? 4'b1100 : 4'b0011;
            2'b10:   s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Store data is copied onto every lane, so the slave finds it under sel_o.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Move the addressed lane(s) of the bus word down to bit 0 and extend.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                                 input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        logic [31:0] r;
        sh = 32'h0;
        r  = w;
        case (size)
            2'b00: begin
                sh = w >> {a, 3'b000};
                r  = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
            end
            2'b01: begin
                sh = w >> {a[1], 4'b0000};
                r  = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            end
            default: r = w;
        endcase
        return r;
    endfunction

    // Request fields are captured on acceptance and left untouched until the
    // next acceptance. The bus therefore sees stable values in BUS and GAP.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        size_d    = size_q;
        signed_d  = signed_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        tmo_cnt_d = tmo_cnt_q;
        rty_cnt_d = rty_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    we_d      = bus.req_we_i;
                    addr_d    = bus.req_addr_i;
                    size_d    = bus.req_size_i;
                    signed_d  = bus.req_signed_i;
                    sel_d     = lane_sel(bus.req_size_i, bus.req_addr_i[1:0]);
                    wdata_d   = lane_data(bus.req_size_i, bus.req_wdata_i);
                    rdata_d   = 32'h0;
                    err_d     = 1'b0;
                    tmo_cnt_d = 16'h0;
                    rty_cnt_d = '0;
                    if ((bus.req_size_i == 2'b11) ||
                        (bus.req_size_i == 2'b01 && bus.req_addr_i[0]) ||
                        (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (bus.err_i) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (bus.ack_i) begin
                    if (!we_q) begin
                        rdata_d = load_extract(bus.dat_i, addr_q[1:0], size_q, signed_q);
                    end
                    state_d = S_RESP;
                end else if (bus.rty_i) begin
                    if (rty_cnt_q < RTY_MAX) begin
                        rty_cnt_d = rty_cnt_q + RW'(1);
                        state_d   = S_GAP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'h1;
                end
            end
            S_GAP: begin
                tmo_cnt_d = 16'h0;
                state_d   = S_BUS;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers. Reset abandons any transfer in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            sel_q     <= 4'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            tmo_cnt_q <= 16'h0;
            rty_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            signed_q  <= signed_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            tmo_cnt_q <= tmo_cnt_d;
            rty_cnt_q <= rty_cnt_d;
        end
    end

    // Outputs decode straight from registered state. cyc/stb are high only in BUS.
    always_comb begin
        bus.req_ready_o = (state_q == S_IDLE);
        bus.rsp_valid_o = (state_q == S_RESP);
        bus.rsp_err_o   = (state_q == S_RESP) && err_q;
        bus.rsp_rdata_o = (state_q == S_RESP) ? rdata_q : 32'h0;
        bus.cyc_o       = (state_q == S_BUS);
        bus.stb_o       = (state_q == S_BUS);
        bus.we_o        = (state_q == S_BUS) && we_q;
        bus.adr_o       = {addr_q[31:2], 2'b00};
        bus.sel_o       = sel_q;
        bus.dat_o       = wdata_q;
        dbg_state_o     = state_q;
    end

endmodule

// File: tb/tb_wb_load_store_master.sv
// Directed bench for wb_load_store_master. dut0 (timeout 8, three retries)
// sits in front of a small memory model at 0x1000. It also sees an
// erroring page at 0x2000 and can be switched into a rty-twice-then-ack slave.
// dut1 (one retry) faces a rty-twice-then-ack slave only.
module tb_wb_load_store_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_load_store_master_if bus0();
    wb_load_store_master_if bus1();
    logic [1:0] dbg0, dbg1;

    wb_load_store_master #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(3)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus0), .dbg_state_o(dbg0)
    );
    wb_load_store_master #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus1), .dbg_state_o(dbg1)
    );

    // ---------------- slave model for dut0 ----------------
    logic [31:0] mem [0:15];
    logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
    logic [31:0] s_dat = 32'h0;
    logic        retry_mode = 1'b0;
    int          rty_seen = 0;
    logic        stray_ack = 1'b0, stray_err = 1'b0;

    always @(posedge clk) begin
        s_ack <= 1'b0;
        s_err <= 1'b0;
        s_rty <= 1'b0;
        if (!retry_mode) rty_seen <= 0;
        if (bus0.cyc_o && bus0.stb_o && !s_ack && !s_err && !s_rty) begin
            if (retry_mode) begin
                if (rty_seen < 2) begin
                    s_rty    <= 1'b1;
                    rty_seen <= rty_seen + 1;
                end else begin
                    s_ack <= 1'b1;
                    s_dat <= 32'h12345678;
                end
            end else if (bus0.adr_o[31:6] == 26'h40) begin
                s_ack <= 1'b1;
                s_dat <= mem[bus0.adr_o[5:2]];
                if (bus0.we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (bus0.sel_o[b]) mem[bus0.adr_o[5:2]][8*b +: 8] <= bus0.dat_o[8*b +: 8];
                end
            end else if (bus0.adr_o[31:12] == 20'h2) begin
                s_err <= 1'b1;
            end
        end
    end

    assign bus0.ack_i = s_ack | stray_ack;
    assign bus0.err_i = s_err | stray_err;
    assign bus0.rty_i = s_rty;
    assign bus0.dat_i = s_dat;

    // ---------------- slave model for dut1 ----------------
    logic s1_ack = 1'b0, s1_rty = 1'b0;
    int   s1_rty_n = 0;
    always @(posedge clk) begin
        s1_ack <= 1'b0;
        s1_rty <= 1'b0;
        if (bus1.cyc_o && bus1.stb_o && !s1_ack && !s1_rty) begin
            if (s1_rty_n < 2) begin
                s1_rty   <= 1'b1;
                s1_rty_n <= s1_rty_n + 1;
            end else begin
                s1_ack <= 1'b1;
            end
        end
    end
    assign bus1.ack_i = s1_ack;
    assign bus1.err_i = 1'b0;
    assign bus1.rty_i = s1_rty;
    assign bus1.dat_i = 32'h0BAD0BAD;

    // ---------------- scoreboard helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_stb;
        logic [3:0]  exp_sel;
        logic [31:0] exp_dat;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic sgn, input logic [31:0] wdata, input logic [31:0] rd,
                                input logic err, input int lat, input int stb,
                                input logic [3:0] sel, input logic [31:0] dat);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.sgn = sgn; v.wdata = wdata;
        v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat; v.exp_stb = stb;
        v.exp_sel = sel; v.exp_dat = dat;
        return v;
    endfunction

    // Results of the last run_req on dut0
    logic        r_seen;
    int          r_lat, r_stb, r_gaps, r_adr_bad;
    logic [31:0] r_rdata;
    logic        r_err, r_we, r_pulse_ok;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;

    // One request on dut0. Cycle 1 is the cycle right after the accepting edge.
    // While the DUT is busy, the request fields are scrambled with valid low.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata);
        int n;
        int last_stb;
        int w;
        r_seen = 1'b0; r_lat = 0; r_stb = 0; r_gaps = 0; r_adr_bad = 0;
        r_rdata = 32'h0; r_err = 1'b0; r_we = 1'b0; r_sel = 4'h0; r_dat = 32'h0;
        r_pulse_ok = 1'b0;
        @(negedge clk);
        bus0.req_valid_i  = 1'b1;
        bus0.req_we_i     = we;
        bus0.req_addr_i   = addr;
        bus0.req_size_i   = size;
        bus0.req_signed_i = sgn;
        bus0.req_wdata_i  = wdata;
        w = 0;
        while (!bus0.req_ready_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        n = 0;
        last_stb = -1;
        while (!r_seen && n < 100) begin
            @(negedge clk);
            n++;
            bus0.req_valid_i  = 1'b0;
            bus0.req_addr_i   = $urandom;
            bus0.req_wdata_i  = $urandom;
            bus0.req_size_i   = 2'($urandom_range(0, 3));
            bus0.req_we_i     = 1'($urandom_range(0, 1));
            bus0.req_signed_i = 1'($urandom_range(0, 1));
            if (bus0.stb_o) begin
                r_stb++;
                r_sel = bus0.sel_o;
                r_dat = bus0.dat_o;
                r_we  = bus0.we_o;
                if (bus0.adr_o !== {addr[31:2], 2'b00}) r_adr_bad++;
                if (last_stb >= 0 && n - last_stb > 1) r_gaps += n - last_stb - 1;
                last_stb = n;
            end
            if (bus0.rsp_valid_o) begin
                r_seen  = 1'b1;
                r_lat   = n;
                r_rdata = bus0.rsp_rdata_o;
                r_err   = bus0.rsp_err_o;
            end
        end
        if (r_seen) begin
            @(negedge clk);
            r_pulse_ok = !bus0.rsp_valid_o && bus0.req_ready_o;
        end
    endtask

    vec_t vecs[$];

    initial begin
        int n;
        int bad;
        logic seen, err1;
        logic [31:0] rd1;
        int lat1, starts;
        logic prev;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        bus0.req_valid_i = 1'b0; bus0.req_we_i = 1'b0; bus0.req_addr_i = 32'h0;
        bus0.req_size_i = 2'b00; bus0.req_signed_i = 1'b0; bus0.req_wdata_i = 32'h0;
        bus1.req_valid_i = 1'b0; bus1.req_we_i = 1'b0; bus1.req_addr_i = 32'h0;
        bus1.req_size_i = 2'b00; bus1.req_signed_i = 1'b0; bus1.req_wdata_i = 32'h0;

        // ---- clock/reset ----
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", {31'h0, bus0.req_ready_o}, 32'h1);
        chk("reset rsp_valid", {31'h0, bus0.rsp_valid_o}, 32'h0);
        chk("reset rsp_err", {31'h0, bus0.rsp_err_o}, 32'h0);
        chk("reset rsp_rdata", bus0.rsp_rdata_o, 32'h0);
        chk("reset cyc/stb/we", {29'h0, bus0.cyc_o, bus0.stb_o, bus0.we_o}, 32'h0);
        chk("reset adr", bus0.adr_o, 32'h0);
        chk("reset sel", {28'h0, bus0.sel_o}, 32'h0);
        chk("reset dat", bus0.dat_o, 32'h0);
        chk("reset state", {30'h0, dbg0}, 32'h0);
        rst_n = 1'b1;

        // ---- terminations while idle are ignored ----
        stray_ack = 1'b1;
        stray_err = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus0.rsp_valid_o || bus0.cyc_o || !bus0.req_ready_o) bad++;
        end
        stray_ack = 1'b0;
        stray_err = 1'b0;
        chk("stray termination in idle", bad, 0);

        // ---- table of directed vectors ----
        //             we    addr          sz     sgn   wdata         rdata         err   lat stb sel      dat
        vecs.push_back(mk(1, 32'h0000_1000, 2'b10, 0, 32'hDEADBEEF, 32'h0000_0000, 0, 3, 2, 4'b1111, 32'hDEADBEEF));
        vecs.push_back(mk(1, 32'h0000_1002, 2'b00, 0, 32'h123456A5, 32'h0000_0000, 0, 3, 2, 4'b0100, 32'hA5A5A5A5));
        vecs.push_back(mk(0, 32'h0000_1000, 2'b10, 0, 32'h0,        32'hDEA5BEEF, 0, 3, 2, 4'b1111, 32'h0));
        vecs.push_back(mk(0, 32'h0000_1002, 2'b00, 1, 32'h0,        32'hFFFFFFA5, 0, 3, 2, 4'b0100, 32'h0));
        vecs.push_back(mk(0, 32'h0000_1002, 2'b00, 0, 32'h0,        32'h000000A5, 0, 3, 2, 4'b0100, 32'h0));
        vecs.push_back(mk(0, 32'h0000_1002, 2'b01, 1, 32'h0,        32'hFFFFDEA5, 0, 3, 2, 4'b1100, 32'h0));
        vecs.push_back(mk(0, 32'h0000_1000, 2'b01, 0, 32'h0,        32'h0000BEEF, 0, 3, 2, 4'b0011, 32'h0));
        vecs.push_back(mk(0, 32'h0000_1001, 2'b00, 0, 32'h0,        32'h000000BE, 0, 3, 2, 4'b0010, 32'h0));
        vecs.push_back(mk(0, 32'h0000_1003, 2'b00, 1, 32'h0,        32'hFFFFFFDE, 0, 3, 2, 4'b1000, 32'h0));
        vecs.push_back(mk(1, 32'h0000_1006, 2'b01, 0, 32'hABCD7F01, 32'h0000_0000, 0, 3, 2, 4'b1100, 32'h7F017F01));
        vecs.push_back(mk(0, 32'h0000_1006, 2'b01, 1, 32'h0,        32'h00007F01, 0, 3, 2, 4'b1100, 32'h0));
        vecs.push_back(mk(0, 32'h0000_1004, 2'b10, 0, 32'h0,        32'h7F010000, 0, 3, 2, 4'b1111, 32'h0));
        vecs.push_back(mk(0, 32'h0000_1001, 2'b01, 0, 32'h0,        32'h0000_0000, 1, 1, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 32'h0000_1000, 2'b11, 0, 32'h0,        32'h0000_0000, 1, 1, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(1, 32'h0000_1002, 2'b10, 0, 32'h11111111, 32'h0000_0000, 1, 1, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 32'h0000_1000, 2'b10, 0, 32'h0,        32'hDEA5BEEF, 0, 3, 2, 4'b1111, 32'h0));
        vecs.push_back(mk(0, 32'h0000_2000, 2'b10, 0, 32'h0,        32'h0000_0000, 1, 3, 2, 4'b1111, 32'h0));
        vecs.push_back(mk(0, 32'h0000_0000, 2'b10, 0, 32'h0,        32'h0000_0000, 1, 9, 8, 4'b1111, 32'h0));

        foreach (vecs[i]) begin
            run_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].wdata);
            chk($sformatf("v%0d response seen", i), {31'h0, r_seen}, 32'h1);
            chk($sformatf("v%0d rdata", i), r_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d err", i), {31'h0, r_err}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d latency", i), r_lat, vecs[i].exp_lat);
            chk($sformatf("v%0d stb cycles", i), r_stb, vecs[i].exp_stb);
            chk($sformatf("v%0d single pulse", i), {31'h0, r_pulse_ok}, 32'h1);
            if (vecs[i].exp_stb > 0) begin
                chk($sformatf("v%0d adr stable", i), r_adr_bad, 0);
                chk($sformatf("v%0d sel", i), {28'h0, r_sel}, {28'h0, vecs[i].exp_sel});
                chk($sformatf("v%0d dat", i), r_dat, vecs[i].exp_dat);
                chk($sformatf("v%0d we", i), {31'h0, r_we}, {31'h0, vecs[i].we});
            end
        end

        // ---- retry twice then ack, three retries allowed ----
        @(negedge clk);
        retry_mode = 1'b1;
        run_req(1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0);
        retry_mode = 1'b0;
        chk("retry response seen", {31'h0, r_seen}, 32'h1);
        chk("retry rdata", r_rdata, 32'h12345678);
        chk("retry err", {31'h0, r_err}, 32'h0);
        chk("retry latency", r_lat, 9);
        chk("retry gap cycles", r_gaps, 2);
        chk("retry stb cycles", r_stb, 6);
        chk("retry adr stable", r_adr_bad, 0);

        // ---- reset while stb is high ----
        @(negedge clk);
        bus0.req_valid_i = 1'b1; bus0.req_we_i = 1'b0; bus0.req_addr_i = 32'h0;
        bus0.req_size_i = 2'b10; bus0.req_signed_i = 1'b0; bus0.req_wdata_i = 32'h0;
        @(posedge clk);
        @(negedge clk);
        bus0.req_valid_i = 1'b0;
        @(negedge clk);
        chk("stb high before reset", {31'h0, bus0.stb_o}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("cyc/stb after reset edge", {30'h0, bus0.cyc_o, bus0.stb_o}, 32'h0);
        chk("req_ready after reset edge", {31'h0, bus0.req_ready_o}, 32'h1);
        rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus0.rsp_valid_o || bus0.cyc_o) bad++;
        end
        chk("no response after reset abort", bad, 0);
        run_req(1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0);
        chk("post-reset rdata", r_rdata, 32'hDEA5BEEF);
        chk("post-reset err", {31'h0, r_err}, 32'h0);
        chk("post-reset latency", r_lat, 3);

        // ---- dut1: one retry allowed, error after second rty ----
        @(negedge clk);
        bus1.req_valid_i = 1'b1; bus1.req_we_i = 1'b0; bus1.req_addr_i = 32'h0000_1000;
        bus1.req_size_i = 2'b10; bus1.req_signed_i = 1'b0; bus1.req_wdata_i = 32'h0;
        @(posedge clk);
        n = 0; seen = 1'b0; err1 = 1'b0; rd1 = 32'h0; lat1 = 0; starts = 0; prev = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            bus1.req_valid_i = 1'b0;
            if (bus1.stb_o && !prev) starts++;
            prev = bus1.stb_o;
            if (bus1.rsp_valid_o) begin
                seen = 1'b1;
                lat1 = n;
                err1 = bus1.rsp_err_o;
                rd1  = bus1.rsp_rdata_o;
            end
        end
        chk("retry-exhaust response seen", {31'h0, seen}, 32'h1);
        chk("retry-exhaust err", {31'h0, err1}, 32'h1);
        chk("retry-exhaust rdata", rd1, 32'h0);
        chk("retry-exhaust latency", lat1, 6);
        chk("retry-exhaust bus attempts", starts, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_load_store_master.md
Name: wb_load_store_master

Overview:
- Wishbone B4 classic master that turns single CPU load/store requests (byte/half/word) into one bus cycle toward the SoC memory and peripheral slaves.
- Sits directly upstream of the memory slave, between the core's load/store stage and the bus.
- Generates byte selects and write-lane replication, and extracts/extends read data.
- Detects misalignment, slave error, retry and timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles the bus phase waits for ack/err/rty before an error response; range 1..65535.
- MAX_RETRIES, 3: number of re-issues after rty_i before an error response; 0 means the first rty is an error.

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_ni  in  1  synchronous, active-low reset
- req_valid_i  in  1  CPU request valid
- req_ready_o  out  1  request accepted when req_valid_i & req_ready_o
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  32  byte address
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed_i  in  1  sign-extend load result
- req_wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  32  load result, right-aligned and extended; 0 for stores and errors
- rsp_err_o  out  1  qualifies rsp_valid_o: misaligned, illegal size, err_i, retry exhaustion or timeout
- cyc_o, stb_o  out  1  Wishbone cycle and strobe, always equal
- we_o  out  1  Wishbone write enable
- adr_o  out  32  req_addr_i with bits [1:0] forced to 0
- sel_o  out  4  byte lane selects
- dat_o  out  32  write data
- dat_i  in  32  read data
- ack_i, err_i, rty_i  in  1  slave termination

Behaviour:
- Reset (rst_ni low at edge): state IDLE. req_ready_o=1; rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0; cyc_o=stb_o=we_o=0; adr_o, sel_o and dat_o=0; counters cleared.
- Reset mid-transfer: cyc/stb drop at that edge. No response is produced for the aborted request.
- FSM states are IDLE, BUS, GAP and RESP.
- IDLE:
  - req_ready_o=1; the request is registered on accept.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11 -> RESP with error. No bus cycle is issued.
  - Otherwise -> BUS. cyc/stb go high on the edge of acceptance.
- Lane encoding:
  - sel_o: byte = 0001<<addr[1:0]; half = 0011 (addr[1]=0) or 1100; word = 1111.
  - dat_o: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- BUS:
  - cyc/stb/adr/sel/we/dat_o are held stable.
  - Timeout counter increments each cycle.
  - Termination priority is err_i > ack_i > rty_i. Exactly one termination is acted on.
  - ack_i: capture dat_i this cycle; deassert cyc/stb next edge; -> RESP.
  - err_i: -> RESP with error.
  - rty_i: if retry count < MAX_RETRIES, increment it and -> GAP; else -> RESP with error.
  - No termination for TIMEOUT_CYCLES cycles in BUS (counter reset on each re-issue): -> RESP with error, cyc/stb dropped.
- GAP: one cycle with cyc/stb=0, then -> BUS with identical address and data.
- RESP:
  - rsp_valid_o=1 for exactly one cycle; req_ready_o=0; -> IDLE.
  - A new request is accepted in the following cycle.
- Load extraction from captured word W:
  - byte = W>>(8*addr[1:0]) low 8 bits.
  - half = W>>(16*addr[1]) low 16 bits.
  - Zero- or sign-extended per req_signed_i.
  - Stores return 0.
- Latency against a slave that acks the cycle after stb:
  - Accept at edge 0, stb high cycle 1, ack cycle 2, rsp_valid_o cycle 3.
  - Throughput: one request per 4 cycles.
- Terminations arriving outside BUS are ignored.
- req_ready_o=0 outside IDLE. Input changes while not ready have no effect.

Test Plan:
- Slave memory at base 0x1000. Store word 0xDEADBEEF @0x1000, then store byte 0xA5 @0x1002 -> sel_o 0100, dat_o 0xA5A5A5A5. Load word @0x1000 -> rsp_rdata_o 0xDEA5BEEF, rsp_err_o 0, rsp_valid_o exactly 3 cycles after accept.
- Load byte @0x1002: signed -> 0xFFFFFFA5; unsigned -> 0x000000A5. Load half @0x1002: signed -> 0xFFFFDEA5.
- Load half @0x1001 and size 11 @0x1000 -> cyc_o never high; rsp_valid_o with rsp_err_o=1 one cycle after accept; rdata 0.
- Load @0x0000 (no slave) with TIMEOUT_CYCLES=8 -> stb held 8 cycles, then dropped; error response.
- Model slave: rty twice, then ack with 0x12345678, MAX_RETRIES=3 -> two 1-cycle gaps with identical adr; rdata 0x12345678, no error. Same model with MAX_RETRIES=1 -> error after the second rty.
- rst_ni low while stb is high -> cyc/stb low next edge; no rsp_valid_o; req_ready_o=1; next request completes normally.
